// File: rtl/decoder_pkg.sv
// Shared decode helpers for the registered one-hot decoders.
// Vectors are sized for the widest legal index (6 bits -> 64 outputs); callers size-cast.
package decoder_pkg;

  localparam int DEC_N_DEFAULT = 3;
  localparam int DEC_N_MAX     = 6;
  localparam int DEC_W_MAX     = 1 << DEC_N_MAX;

  // Compare-per-bit rather than a shift: an unknown idx yields zero, never X.
  function automatic logic [DEC_W_MAX-1:0] onehot_dec(input logic [DEC_N_MAX-1:0] idx,
                                                       input logic                 en);
    logic [DEC_W_MAX-1:0] r;
    r = '0;
    if (en) begin
      for (int i = 0; i < DEC_W_MAX; i++) begin
        if (idx == i[DEC_N_MAX-1:0]) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic is_onehot0(input logic [DEC_W_MAX-1:0] vec);
    return (vec & (vec - 1'b1)) == '0;
  endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational, X-safe N-to-2^N one-hot decode; all-zero when ena is low.
// Zero latency, no backpressure.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int N = DEC_N_DEFAULT
) (
  input  logic            ena_i,
  input  logic [N-1:0]    n_i,
  output logic [2**N-1:0] dec_o
);

  localparam int W = 2 ** N;

  always_comb begin
    dec_o = W'(onehot_dec(DEC_N_MAX'(n_i), ena_i));
  end

endmodule

// File: rtl/decoder3_ena.sv
// Registered one-hot decoder with enable; 1-cycle latency, new index every cycle, no handshake.
// DECODER3_ENA_CHECK_EN adds a sticky chk_err self-check on the output register.
module decoder3_ena
  import decoder_pkg::*;
#(
  parameter int N = DEC_N_DEFAULT  // legal 1..6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [N-1:0]    n,
  output logic [2**N-1:0] d,
  output logic            vld
`ifdef DECODER3_ENA_CHECK_EN
  ,
  output logic            chk_err
`endif
);

  localparam int W = 2 ** N;

  logic [W-1:0] d_d;
  logic [W-1:0] d_q;
  logic         vld_q;

  decoder_core #(.N(N)) u_core (
    .ena_i (ena),
    .n_i   (n),
    .dec_o (d_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      d_q   <= d_d;
      vld_q <= ena;
    end
  end

  assign d   = d_q;
  assign vld = vld_q;

`ifdef DECODER3_ENA_CHECK_EN
  logic chk_err_d;
  logic chk_err_q;

  // Flags a corrupted output register: multi-hot, or d disagreeing with vld.
  always_comb begin
    chk_err_d = chk_err_q
              | ~is_onehot0(DEC_W_MAX'(d_q))
              | (vld_q && (d_q == '0))
              | (!vld_q && (d_q != '0));
  end

  always_ff @(posedge clk) begin
    if (rst) chk_err_q <= 1'b0;
    else     chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_decoder3_ena.sv
// Scoreboard bench for decoder3_ena: N=3 and N=2 instances driven side by side.
module tb_decoder3_ena;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [2:0] n;
  logic [7:0] d;
  logic       vld;
  logic       ena2;
  logic [1:0] n2;
  logic [3:0] d2;
  logic       vld2;
`ifdef DECODER3_ENA_CHECK_EN
  logic       chk_err;
  logic       chk_err2;
`endif

  decoder3_ena #(.N(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .n   (n),
    .d   (d),
    .vld (vld)
`ifdef DECODER3_ENA_CHECK_EN
    ,
    .chk_err (chk_err)
`endif
  );

  decoder3_ena #(.N(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .ena (ena2),
    .n   (n2),
    .d   (d2),
    .vld (vld2)
`ifdef DECODER3_ENA_CHECK_EN
    ,
    .chk_err (chk_err2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic [3:0] d2;
    logic       v2;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Monitor: one registered result per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t ex;
    if (exp_q.size() != 0) begin
      ex = exp_q.pop_front();
      check("d",    d,             ex.d);
      check("vld",  {7'b0, vld},   {7'b0, ex.v});
      check("d2",   {4'b0, d2},    {4'b0, ex.d2});
      check("vld2", {7'b0, vld2},  {7'b0, ex.v2});
`ifdef DECODER3_ENA_CHECK_EN
      check("chk_err",  {7'b0, chk_err},  8'h00);
      check("chk_err2", {7'b0, chk_err2}, 8'h00);
`endif
    end
  end

  task automatic step(input logic r, input logic e, input logic [2:0] nn,
                      input logic [7:0] xd, input logic xv,
                      input logic e2, input logic [1:0] nn2, input logic [3:0] xd2);
    exp_t ex;
    rst  = r;
    ena  = e;
    n    = nn;
    ena2 = e2;
    n2   = nn2;
    @(posedge clk);
    #1;
    ex.d  = xd;
    ex.v  = xv;
    ex.d2 = xd2;
    ex.v2 = e2 & ~r;
    exp_q.push_back(ex);
  endtask

  logic [7:0] sweep_d  [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [3:0] sweep_d2 [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};

  initial begin
    // Reset held two cycles with ena=1, n=5: outputs stay clear.
    step(1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 1'b1, 2'd3, 4'h0);
    step(1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 1'b1, 2'd3, 4'h0);
    step(1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 1'b1, 2'd3, 4'h8);

    // Full index sweep, back to back.
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, i[2:0], sweep_d[i], 1'b1, 1'b1, i[1:0], sweep_d2[i]);

    // Disabled with unknown index must give clean zeros.
    step(1'b0, 1'b0, 3'bxxx, 8'h00, 1'b0, 1'b0, 2'd3,  4'h0);
    step(1'b0, 1'b0, 3'bxxx, 8'h00, 1'b0, 1'b0, 2'bxx, 4'h0);

    // Sweep interrupted by a one-cycle reset at n=4.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, i[2:0], sweep_d[i], 1'b1, 1'b1, i[1:0], sweep_d2[i]);
    step(1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b1, 2'd0, 4'h0);
    step(1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 1'b1, 2'd1, 4'h2);
    step(1'b0, 1'b1, 3'd6, 8'h40, 1'b1, 1'b1, 2'd2, 4'h4);

    // Enable toggling between consecutive indices.
    step(1'b0, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 2'd3, 4'h0);
    step(1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 1'b1, 2'd3, 4'h8);
    step(1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 2'd3, 4'h0);
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 2'd0, 4'h1);

    @(negedge clk);
    #1;
    chk_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    else
      pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
